// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: blanking values, digit count and the
// active-low hex glyphs, segment order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] ALL_OFF    = 8'hFF;
    localparam int         NUM_DIGITS = 8;

    localparam logic [6:0] HEX_0 = 7'h40;
    localparam logic [6:0] HEX_1 = 7'h79;
    localparam logic [6:0] HEX_2 = 7'h24;
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_4 = 7'h19;
    localparam logic [6:0] HEX_5 = 7'h12;
    localparam logic [6:0] HEX_6 = 7'h02;
    localparam logic [6:0] HEX_7 = 7'h78;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
    localparam logic [6:0] HEX_A = 7'h08;
    localparam logic [6:0] HEX_B = 7'h03;
    localparam logic [6:0] HEX_C = 7'h46;
    localparam logic [6:0] HEX_D = 7'h21;
    localparam logic [6:0] HEX_E = 7'h06;
    localparam logic [6:0] HEX_F = 7'h0E;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = HEX_0;
            4'h1: seg = HEX_1;
            4'h2: seg = HEX_2;
            4'h3: seg = HEX_3;
            4'h4: seg = HEX_4;
            4'h5: seg = HEX_5;
            4'h6: seg = HEX_6;
            4'h7: seg = HEX_7;
            4'h8: seg = HEX_8;
            4'h9: seg = HEX_9;
            4'hA: seg = HEX_A;
            4'hB: seg = HEX_B;
            4'hC: seg = HEX_C;
            4'hD: seg = HEX_D;
            4'hE: seg = HEX_E;
            4'hF: seg = HEX_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// 8-digit time-multiplexed seven-segment scanner with once-per-frame snapshot of num_a/num_b.
// Optional leading-zero blanking per 4-digit group: SEG_SCAN_BLANK_LEADING_ZEROS_EN.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num_a,
    input  logic [15:0] num_b,
    input  logic        hold,
    output logic [6:0]  out7,
    output logic [7:0]  en_out
);

    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    logic [PRESC_W-1:0] presc;
    logic [IDX_W-1:0]   idx;
    logic               load_pend;
    logic [15:0]        shadow_a;
    logic [15:0]        shadow_b;

    logic               tick;
    logic               wrap;
    logic               snap;
    logic [31:0]        shadow_all;
    logic [3:0]         nibble;
    logic [6:0]         seg;
    logic [7:0]         blank;
    logic               blank_sel;

    assign tick = (presc == PRESC_W'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    // The first cycle after reset always attempts a load; if hold blocks it, it is lost.
    assign snap = (load_pend || wrap) && !hold;

    // Digit i shows nibble i of {shadow_a, shadow_b}: digit 0 is shadow_b[3:0].
    assign shadow_all = {shadow_a, shadow_b};
    assign nibble     = shadow_all[{idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (seg)
    );

`ifdef SEG_SCAN_BLANK_LEADING_ZEROS_EN
    // A digit is blanked when it and every more significant digit of its group are zero;
    // the least significant digit of each group always stays lit.
    always_comb begin
        blank    = '0;
        blank[1] = ~|shadow_b[15:4];
        blank[2] = ~|shadow_b[15:8];
        blank[3] = ~|shadow_b[15:12];
        blank[5] = ~|shadow_a[15:4];
        blank[6] = ~|shadow_a[15:8];
        blank[7] = ~|shadow_a[15:12];
    end
`else
    assign blank = '0;
`endif

    assign blank_sel = blank[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            idx       <= '0;
            load_pend <= 1'b1;
            shadow_a  <= '0;
            shadow_b  <= '0;
            out7      <= SEG_OFF;
            en_out    <= ALL_OFF;
        end else begin
            presc     <= tick ? '0 : presc + PRESC_W'(1);
            if (tick)
                idx <= idx + IDX_W'(1);
            load_pend <= 1'b0;
            if (snap) begin
                shadow_a <= num_a;
                shadow_b <= num_b;
            end
            out7   <= blank_sel ? SEG_OFF : seg;
            en_out <= blank_sel ? ALL_OFF : ~(8'b1 << idx);
        end
    end

endmodule
